// File: rtl/key_event_decoder.sv
// Per-key event decoder: turns a debounced key level into single-cycle
// press/release/short/long/repeat pulses plus a registered key_held level.
module key_event_decoder #(
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_REL,
        S_IDLE,
        S_PRESS,
        S_LONG
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_press_pulse, r_release_pulse, r_short_press;
    logic r_long_press, r_repeat_pulse, r_key_held;
    logic w_press_nxt, w_release_nxt, w_short_nxt;
    logic w_long_nxt, w_repeat_nxt, w_held_nxt;

    logic w_pressed;
    assign w_pressed = key_level ^ ACTIVE_LOW;

    // State, hold counter and all outputs share one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_WAIT_REL;
            r_cnt           <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_short_press   <= 1'b0;
            r_long_press    <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            r_key_held      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            r_short_press   <= w_short_nxt;
            r_long_press    <= w_long_nxt;
            r_repeat_pulse  <= w_repeat_nxt;
            r_key_held      <= w_held_nxt;
        end
    end

    // Release is tested before terminal count so it wins on a coincident edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;

        case (r_state)
            S_WAIT_REL: begin
                if (!w_pressed) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = S_PRESS;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end
            end
            S_PRESS: begin
                if (!w_pressed) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_short_nxt   = 1'b1;
                end else if (r_cnt == LONG_TC) begin
                    w_state_nxt = S_LONG;
                    w_cnt_nxt   = '0;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LONG: begin
                if (!w_pressed) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (r_cnt == REPEAT_TC) begin
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = REPEAT_EN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_WAIT_REL;
                w_cnt_nxt   = '0;
            end
        endcase

        w_held_nxt = (w_state_nxt == S_PRESS) || (w_state_nxt == S_LONG);
    end

    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign short_press   = r_short_press;
    assign long_press    = r_long_press;
    assign repeat_pulse  = r_repeat_pulse;
    assign key_held      = r_key_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: active-high and active-low instances share one
// scoreboard fed by a vector table and a hold-time reference model.
module tb_key_event_decoder;

    localparam int unsigned LONG = 20;
    localparam int unsigned REP  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;
    logic key_n;
    assign key_n = ~key;

    logic a_press, a_rel, a_shrt, a_lng, a_rep, a_held;
    logic b_press, b_rel, b_shrt, b_lng, b_rep, b_held;

    key_event_decoder #(.ACTIVE_LOW(1'b0), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
                        .REPEAT_EN(1'b1), .CNT_W(8)) u_hi (
        .clk(clk), .rst(rst), .key_level(key),
        .press_pulse(a_press), .release_pulse(a_rel), .short_press(a_shrt),
        .long_press(a_lng), .repeat_pulse(a_rep), .key_held(a_held));

    key_event_decoder #(.ACTIVE_LOW(1'b1), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
                        .REPEAT_EN(1'b1), .CNT_W(8)) u_lo (
        .clk(clk), .rst(rst), .key_level(key_n),
        .press_pulse(b_press), .release_pulse(b_rel), .short_press(b_shrt),
        .long_press(b_lng), .repeat_pulse(b_rep), .key_held(b_held));

    always #5 clk = ~clk;

    typedef struct packed {
        logic press;
        logic rel;
        logic shrt;
        logic lng;
        logic rep;
        logic held;
    } exp_t;

    typedef struct {
        logic r;
        logic p;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t rows[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model expressed as edges elapsed since the accepting press edge.
    int m_st = 0;  // 0 wait-release, 1 idle, 2 held
    int m_t  = 0;
    int n_push = 0;

    task automatic model_step(input logic r, input logic p, output exp_t e);
        e = '0;
        if (r) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (!p) m_st = 1;
        end else if (m_st == 1) begin
            if (p) begin
                m_st = 2;
                m_t = 0;
                e.press = 1'b1;
            end
        end else begin
            m_t = m_t + 1;
            if (!p) begin
                e.rel  = 1'b1;
                e.shrt = (m_t <= int'(LONG));
                m_st   = 1;
            end else begin
                e.lng = (m_t == int'(LONG));
                e.rep = (m_t > int'(LONG)) && (((m_t - int'(LONG)) % int'(REP)) == 0);
            end
        end
        e.held = (m_st == 2);
    endtask

    task automatic drive(input logic r, input logic p, input bit use_tbl, input exp_t te);
        exp_t me;
        @(negedge clk);
        rst = r;
        key = p;
        model_step(r, p, me);
        sb.push_back(use_tbl ? te : me);
        n_push = n_push + 1;
    endtask

    task automatic run(input logic r, input logic p, input int n);
        for (int i = 0; i < n; i++) drive(r, p, 1'b0, '0);
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
        #2;
        chki("scoreboard_drained", sb.size(), 0);
    endtask

    function automatic vec_t mk(logic r, logic p, logic [5:0] o);
        vec_t v;
        v.r = r;
        v.p = p;
        v.e = exp_t'(o);
        return v;
    endfunction

    // Observation counters and event indices from the active-high instance.
    exp_t ce;
    int   idx = 0;
    int   n_long = 0, n_rep = 0, n_short = 0, n_held = 0, n_press = 0, n_rel = 0;
    int   press_idx = -1, long_idx = -1;
    int   rep_idx[$];

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            ce = sb.pop_front();
            chk("hi.press_pulse", a_press, ce.press);
            chk("hi.release_pulse", a_rel, ce.rel);
            chk("hi.short_press", a_shrt, ce.shrt);
            chk("hi.long_press", a_lng, ce.lng);
            chk("hi.repeat_pulse", a_rep, ce.rep);
            chk("hi.key_held", a_held, ce.held);
            chk("lo.press_pulse", b_press, ce.press);
            chk("lo.release_pulse", b_rel, ce.rel);
            chk("lo.short_press", b_shrt, ce.shrt);
            chk("lo.long_press", b_lng, ce.lng);
            chk("lo.repeat_pulse", b_rep, ce.rep);
            chk("lo.key_held", b_held, ce.held);
            if (a_press) begin n_press = n_press + 1; press_idx = idx; end
            if (a_lng)   begin n_long = n_long + 1; long_idx = idx; end
            if (a_rep)   begin n_rep = n_rep + 1; rep_idx.push_back(idx); end
            if (a_shrt)  n_short = n_short + 1;
            if (a_rel)   n_rel = n_rel + 1;
            if (a_held)  n_held = n_held + 1;
            idx = idx + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_long, s_rep, s_short, s_held, s_press, s_rel, p_idx;

        // Test 1 as an explicit vector table: {press,rel,short,long,rep,held}
        rows.push_back(mk(1'b1, 1'b0, 6'b000000));
        rows.push_back(mk(1'b1, 1'b0, 6'b000000));
        rows.push_back(mk(1'b0, 1'b0, 6'b000000));
        rows.push_back(mk(1'b0, 1'b1, 6'b100001));
        for (int i = 0; i < 9; i++) rows.push_back(mk(1'b0, 1'b1, 6'b000001));
        rows.push_back(mk(1'b0, 1'b0, 6'b011000));
        rows.push_back(mk(1'b0, 1'b0, 6'b000000));
        rows.push_back(mk(1'b0, 1'b0, 6'b000000));

        s_held = n_held;
        for (int i = 0; i < rows.size(); i++) drive(rows[i].r, rows[i].p, 1'b1, rows[i].e);
        flush();
        chki("t1_held_cycles", n_held - s_held, 10);
        chki("t1_long_count", n_long, 0);

        // Test 2: hold 32 cycles -> long at +20, repeats at +25 and +30
        s_short = n_short; s_rel = n_rel;
        p_idx = n_push;
        run(1'b0, 1'b1, 32);
        run(1'b0, 1'b0, 3);
        flush();
        chki("t2_press_idx", press_idx, p_idx);
        chki("t2_long_offset", long_idx - p_idx, int'(LONG));
        chki("t2_repeat_count", rep_idx.size(), 2);
        if (rep_idx.size() == 2) begin
            chki("t2_rep1_offset", rep_idx[0] - p_idx, int'(LONG + REP));
            chki("t2_rep2_offset", rep_idx[1] - p_idx, int'(LONG + 2 * REP));
        end
        chki("t2_short_count", n_short - s_short, 0);
        chki("t2_release_count", n_rel - s_rel, 1);

        // Test 3: key held through reset release -> silent until released
        s_press = n_press; s_held = n_held;
        run(1'b1, 1'b1, 2);
        run(1'b0, 1'b1, 40);
        flush();
        chki("t3_no_press", n_press - s_press, 0);
        chki("t3_no_held", n_held - s_held, 0);
        run(1'b0, 1'b0, 2);
        run(1'b0, 1'b1, 3);
        run(1'b0, 1'b0, 2);
        flush();
        chki("t3_press_after_release", n_press - s_press, 1);

        // Test 4: release exactly on the terminal-count edge
        s_long = n_long; s_short = n_short;
        run(1'b0, 1'b1, int'(LONG));
        run(1'b0, 1'b0, 3);
        flush();
        chki("t4_long_count", n_long - s_long, 0);
        chki("t4_short_count", n_short - s_short, 1);

        // Test 5: reset while in LONG, key stays down afterwards
        s_press = n_press; s_rep = n_rep;
        run(1'b0, 1'b1, 24);
        drive(1'b1, 1'b1, 1'b1, '0);
        run(1'b0, 1'b1, 8);
        flush();
        chki("t5_single_press", n_press - s_press, 1);
        chki("t5_no_repeat_after_rst", n_rep - s_rep, 0);
        run(1'b0, 1'b0, 2);
        run(1'b0, 1'b1, 4);
        run(1'b0, 1'b0, 2);
        flush();
        chki("t5_press_after_rst", n_press - s_press, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
